// File: rtl/sprite_arb_pkg.sv
// Shared types and helpers for the sprite ROM arbiter.
// Holds the arbiter FSM states, the response pipeline entry and the index-width helper.
package sprite_arb_pkg;

   // Sized for the largest supported build (8 requesters).
   localparam int IDX_W = 3;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } rsp_pipe_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// The search starts at ptr and wraps modulo N; the first set request wins.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int j;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      // Walk from farthest to nearest so the nearest hit is written last.
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = IW'(j);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with burst locking for one shared synchronous sprite ROM port.
// Optional macro SPRITE_ARB_DISPLAY_PRIO_EN gives requester 0 absolute priority while blank=1.
module sprite_rom_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 3,
   parameter int ROM_LAT   = 1,
   parameter int MAX_BURST = 32
) (
   input  logic                    vga_clk,
   input  logic                    reset,
   input  logic                    blank,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_lock,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]       rom_address,
   input  logic [DATA_W-1:0]       rom_q,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data
);

   localparam int IW   = idx_width(N_REQ);
   localparam int BC_W = $clog2(MAX_BURST + 1);

   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
      return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
   endfunction

   arb_state_e        state, state_n;
   logic [IW-1:0]     owner, owner_n;
   logic [IW-1:0]     rr_ptr, rr_n;
   logic [BC_W-1:0]   burst_cnt, burst_n, burst_inc;

   logic [N_REQ-1:0]  rr_gnt;
   logic [IW-1:0]     rr_idx;
   logic              rr_any;

   logic              win_any;
   logic [IW-1:0]     win_idx;
   logic              prio_hit;
   logic              owner_accept;

   rsp_pipe_t         pipe [ROM_LAT];
   rsp_pipe_t         pipe_in;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (rr_gnt),
      .idx (rr_idx),
      .any (rr_any)
   );

`ifdef SPRITE_ARB_DISPLAY_PRIO_EN
   assign prio_hit = blank & req_valid[0];
`else
   logic unused_blank;
   assign unused_blank = blank;
   assign prio_hit     = 1'b0;
`endif

   // Winner selection: display priority, then the lock owner, then round-robin.
   always_comb begin
      req_ready = '0;
      win_any   = 1'b0;
      win_idx   = '0;
      if (!reset) begin
         if (prio_hit) begin
            req_ready[0] = 1'b1;
            win_any      = 1'b1;
         end else if (state == ARB_LOCKED) begin
            if (req_valid[owner]) begin
               req_ready[owner] = 1'b1;
               win_any          = 1'b1;
               win_idx          = owner;
            end
         end else if (rr_any) begin
            req_ready = rr_gnt;
            win_any   = 1'b1;
            win_idx   = rr_idx;
         end
      end
   end

   assign rom_address = win_any ? req_addr[int'(win_idx)*ADDR_W +: ADDR_W] : '0;

   // A priority grant to requester 0 still counts as an owner accept when 0 owns the lock.
   assign owner_accept = req_valid[owner] && (!prio_hit || owner == '0);
   assign burst_inc    = burst_cnt + BC_W'(1);

   always_comb begin
      state_n = state;
      owner_n = owner;
      rr_n    = rr_ptr;
      burst_n = burst_cnt;
      case (state)
         ARB_IDLE: begin
            if (win_any && !prio_hit) begin
               rr_n = next_ptr(win_idx);
               if (req_lock[win_idx]) begin
                  state_n = ARB_LOCKED;
                  owner_n = win_idx;
                  burst_n = BC_W'(1);
               end
            end
         end
         ARB_LOCKED: begin
            if (!req_valid[owner]) begin
               state_n = ARB_IDLE;
               rr_n    = next_ptr(owner);
               burst_n = '0;
            end else if (owner_accept) begin
               burst_n = burst_inc;
               // Forced release ignores req_lock so the others get a turn.
               if (!req_lock[owner] || burst_inc == BC_W'(MAX_BURST)) begin
                  state_n = ARB_IDLE;
                  rr_n    = next_ptr(owner);
                  burst_n = '0;
               end
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         rr_ptr    <= rr_n;
         burst_cnt <= burst_n;
      end
   end

   always_comb begin
      pipe_in       = '0;
      pipe_in.valid = win_any;
      pipe_in.idx   = IDX_W'(win_idx);
   end

   // NOTE: the response pipeline is reset so pre-reset accepts can never surface afterwards.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int k = 0; k < ROM_LAT; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= pipe_in;
         for (int k = 1; k < ROM_LAT; k++) pipe[k] <= pipe[k-1];
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < N_REQ; i++)
         rsp_valid[i] = !reset && pipe[ROM_LAT-1].valid && (pipe[ROM_LAT-1].idx == IDX_W'(i));
      rsp_data = (|rsp_valid) ? rom_q : '0;
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 1-cycle ROM model returning addr[2:0].
// Display-priority steps compile only when SPRITE_ARB_DISPLAY_PRIO_EN is defined.
module tb_sprite_rom_arbiter;

   logic        vga_clk;
   logic        reset;
   logic        blank;
   logic [3:0]  req_valid;
   logic [3:0]  req_lock;
   logic [39:0] req_addr;
   logic [3:0]  req_ready;
   logic [9:0]  rom_address;
   logic [2:0]  rom_q;
   logic [3:0]  rsp_valid;
   logic [2:0]  rsp_data;

   int total = 0;
   int bad   = 0;

   sprite_rom_arbiter #(
      .N_REQ     (4),
      .ADDR_W    (10),
      .DATA_W    (3),
      .ROM_LAT   (1),
      .MAX_BURST (32)
   ) dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .blank       (blank),
      .req_valid   (req_valid),
      .req_lock    (req_lock),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) rom_q <= rom_address[2:0];

   task automatic tick;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      blank     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic set_lanes;
      for (int i = 0; i < 4; i++) req_addr[i*10 +: 10] = 10'h100 + 10'(i);
   endtask

   initial begin
      reset     = 1'b1;
      blank     = 1'b0;
      req_valid = 4'hF;
      req_lock  = '0;
      req_addr  = '0;
      set_lanes;

      // Outputs idle while reset is held, even with all requesters valid.
      tick;
      #2;
      check("rst_ready", req_ready, 4'b0000);
      check("rst_addr", rom_address, 10'h000);
      check("rst_rsp_valid", rsp_valid, 4'b0000);
      check("rst_rsp_data", rsp_data, 3'b000);

      // Single requester 2 at 0x05A; q = addr[2:0] = 3'b010 one cycle later.
      do_reset;
      req_addr[20 +: 10] = 10'h05A;
      req_valid = 4'b0100;
      #2;
      check("single_ready", req_ready, 4'b0100);
      check("single_addr", rom_address, 10'h05A);
      check("single_rsp_early", rsp_valid, 4'b0000);
      tick;
      req_valid = 4'b0000;
      #2;
      check("single_ready_off", req_ready, 4'b0000);
      check("single_rsp_valid", rsp_valid, 4'b0100);
      check("single_rsp_data", rsp_data, 3'b010);
      tick;
      #2;
      check("single_rsp_once", rsp_valid, 4'b0000);
      check("single_rsp_data0", rsp_data, 3'b000);

      // All four requesting, no locks: grants 0,1,2,3,0,... and responses one cycle behind.
      do_reset;
      set_lanes;
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #2;
         check("rr_ready", req_ready, 32'(1) << (k % 4));
         check("rr_addr", rom_address, 32'h100 + 32'(k % 4));
         if (k > 0) begin
            check("rr_rsp_valid", rsp_valid, 32'(1) << ((k - 1) % 4));
            check("rr_rsp_data", rsp_data, 32'((k - 1) % 4));
         end
         tick;
      end

      // Requester 1 locks: 32 consecutive grants, forced release, then 2,3,0 before 1 again.
      do_reset;
      req_valid = 4'hF;
      req_lock  = 4'b0010;
      for (int k = 0; k < 37; k++) begin
         int exp_i;
         if (k == 0)       exp_i = 0;
         else if (k <= 32) exp_i = 1;
         else              exp_i = (k - 31) % 4;
         #2;
         check("burst_ready", req_ready, 32'(1) << exp_i);
         tick;
      end

      // Lock owner 1 drops valid mid-burst: stall, then IDLE with rr_ptr = 2.
      do_reset;
      req_lock  = 4'b0010;
      req_valid = 4'b1010;
      #2;
      check("drop_lock_grant", req_ready, 4'b0010);
      tick;
      req_valid = 4'b1011;
      #2;
      check("drop_locked_only_owner", req_ready, 4'b0010);
      tick;
      req_valid = 4'b1000;
      #2;
      check("drop_stall", req_ready, 4'b0000);
      tick;
      req_valid = 4'b1101;
      #2;
      check("drop_next_winner", req_ready, 4'b0100);
      check("drop_next_addr", rom_address, 10'h102);
      tick;

      // Reset one cycle after accepting requester 3: its response is discarded.
      do_reset;
      req_lock  = '0;
      req_addr[30 +: 10] = 10'h0F3;
      req_valid = 4'b1000;
      #2;
      check("rstmid_accept3", req_ready, 4'b1000);
      tick;
      reset     = 1'b1;
      req_valid = 4'b0110;
      #2;
      check("rstmid_ready", req_ready, 4'b0000);
      check("rstmid_addr", rom_address, 10'h000);
      check("rstmid_rsp_valid", rsp_valid, 4'b0000);
      check("rstmid_rsp_data", rsp_data, 3'b000);
      tick;
      #2;
      check("rstmid_rsp_hold", rsp_valid, 4'b0000);
      reset = 1'b0;
      #1;
      check("rstmid_first_grant", req_ready, 4'b0010);
      check("rstmid_no_rsp", rsp_valid, 4'b0000);
      tick;
      req_valid = 4'b0000;
      #2;
      check("rstmid_rsp_new", rsp_valid, 4'b0010);
      tick;

`ifdef SPRITE_ARB_DISPLAY_PRIO_EN
      // Requester 2 locked; requester 0 overrides for 3 cycles without consuming the burst.
      set_lanes;
      do_reset;
      blank     = 1'b1;
      req_lock  = 4'b0100;
      req_valid = 4'b0100;
      #2;
      check("prio_lock_grant", req_ready, 4'b0100);
      tick;
      #2;
      check("prio_locked", req_ready, 4'b0100);
      tick;
      req_valid = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         #2;
         check("prio_override", req_ready, 4'b0001);
         tick;
      end
      req_valid = 4'b0110;
      for (int k = 0; k < 31; k++) begin
         #2;
         check("prio_resume", req_ready, (k < 30) ? 32'b0100 : 32'b0010);
         tick;
      end
      blank = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
